pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Two-master to one-slave wishbone arbiter for cache-line traffic.
//  Shares the downstream line port (L2 / evict-buffer path) between the I-cache and D-cache miss ports.
//  Round-robin fairness; each grant is held for one full transaction (through ACK or RTY).
//  Every grant ends with a one-cycle release bubble with CYC low, so the slave's ACK can fall.
// PARAMETERS
//  DATA_W  128  line width, bits
//  ADR_W   12   line address width
//  SEL_W   16   byte-select width (DATA_W/8)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  i_cyc/i_stb in  1 each  I-cache master cycle/strobe
//  i_we       in   1       I-cache write enable
//  i_sel      in   SEL_W   I-cache byte selects
//  i_adr      in   ADR_W   I-cache line address
//  i_dat_m    in   DATA_W  I-cache write data
//  i_dat_s    out  DATA_W  read data to I-cache
//  i_ack/i_rty out 1 each  ACK/RTY to I-cache
//  d_*        same set as i_*, for the D-cache master
//  m_cyc/m_stb out 1 each  downstream cycle/strobe
//  m_we       out  1       downstream write enable
//  m_sel      out  SEL_W   downstream byte selects
//  m_adr      out  ADR_W   downstream address
//  m_dat_m    out  DATA_W  downstream write data
//  m_dat_s    in   DATA_W  downstream read data
//  m_ack/m_rty in  1 each  downstream ACK/RTY
// BEHAVIOUR
//  - Request: x_req = x_cyc & x_stb.
//  - States: IDLE, GRANT_I, GRANT_D, RELEASE. Grant is registered.
//  - Latency: a request seen in IDLE at edge N drives m_cyc in cycle N+1.
//  - Reset: state=IDLE, last=I, so D wins the first tie.
//    All outputs are 0 in the cycle after rst is sampled high, including during an in-flight transfer.
//    Reset mid-operation drops m_cyc/m_stb; no ACK is forwarded.
//  - IDLE: all m_* outputs 0.
//    Only one request: grant it. Both requesting: grant the master != last.
//    No request: stay in IDLE.
//  - GRANT_x: m_cyc/m_stb = x_req; m_we/m_sel/m_adr/m_dat_m = x's inputs, combinationally.
//    x_ack = m_ack, x_rty = m_rty. The other master's ack/rty are 0.
//    i_dat_s = d_dat_s = m_dat_s, always; only valid with ack.
//  - GRANT_x exits on m_ack | m_rty -> RELEASE, and last <= x.
//    If x_req drops before ACK (abort): -> RELEASE, last unchanged.
//    Simultaneous m_ack and x_req drop: counts as completion, last <= x.
//  - RELEASE: exactly 1 cycle. m_* outputs 0, all acks/rtys 0. Then -> IDLE.
//    A requester held through RELEASE is arbitrated in IDLE on the next cycle.
//  - Minimum back-to-back spacing: ACK cycle, RELEASE, IDLE, next grant.
//  - RTY: forwarded only to the granted master, and the grant is released.
//    The master must re-request; the retry competes under normal round-robin.
//  - m_ack/m_rty in IDLE or RELEASE are ignored and never forwarded.
//  - No combinational path from m_ack to m_cyc. Arbitration uses registered state only.
// TESTING
//  1 Reset: hold rst 3 cycles with i_req=d_req=1 -> m_cyc=0, i_ack=d_ack=0.
//    After release, D is granted first (m_adr=d_adr).
//  2 Single read: d_req, d_adr=12'h0A5; slave ACKs 4 cycles after m_cyc.
//    -> d_ack for 1 cycle with d_dat_s=m_dat_s; m_cyc=0 the next cycle; i_ack never 1.
//  3 Contention: both requesting continuously, slave ACKs in 2 cycles.
//    -> grants alternate D,I,D,I; m_adr alternates between d_adr and i_adr.
//    Each grant is separated by a RELEASE cycle with m_cyc=0.
//  4 Write passthrough: i_we=1, i_sel=16'hFFFF, i_dat_m=128'hDEAD..BEEF.
//    -> m_we=1, m_sel/m_dat_m match exactly while granted; i_ack on m_ack.
//  5 Retry: m_rty during GRANT_D with I also requesting.
//    -> d_rty=1 for 1 cycle; RELEASE; I granted next (last=D).
//  6 Abort/reset: drop d_cyc mid-grant -> RELEASE then IDLE, last unchanged.
//    Assert rst mid-grant -> m_cyc=0 the next cycle; no ack to either master.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Wishbone line-port bundle shared by the cache miss ports and the downstream L2 path.
// A bus master drives cyc/stb/we/sel/adr/dat_m; the slave answers with dat_s/ack/rty.
interface pmem_arbiter_if #(
  parameter int DATA_W = 128,
  parameter int ADR_W  = 12,
  parameter int SEL_W  = 16
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] dat_m;
  logic [DATA_W-1:0] dat_s;
  logic              ack;
  logic              rty;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, rty
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, rty
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin two-master wishbone arbiter for I-cache/D-cache line misses onto one
// downstream port. Each grant lasts one transaction and ends with a one-cycle CYC-low bubble.
module pmem_arbiter #(
  parameter int DATA_W = 128,
  parameter int ADR_W  = 12,
  parameter int SEL_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave  i_bus,
  pmem_arbiter_if.slave  d_bus,
  pmem_arbiter_if.master m_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  logic   last_d;
  logic   i_req;
  logic   d_req;
  logic   m_done;

  assign i_req  = i_bus.cyc & i_bus.stb;
  assign d_req  = d_bus.cyc & d_bus.stb;
  assign m_done = m_bus.ack | m_bus.rty;

  // Arbitration and grant lifetime depend only on registered state; m_ack never reaches m_cyc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_req && (!i_req || !last_d)) begin
            state <= GRANT_D;
          end else if (i_req) begin
            state <= GRANT_I;
          end
        end
        GRANT_I: begin
          if (m_done) begin
            state  <= RELEASE;
            last_d <= 1'b0;
          end else if (!i_req) begin
            state <= RELEASE;
          end
        end
        GRANT_D: begin
          if (m_done) begin
            state  <= RELEASE;
            last_d <= 1'b1;
          end else if (!d_req) begin
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The granted master's bus is steered through combinationally; everything else idles at 0.
  always_comb begin
    m_bus.cyc   = 1'b0;
    m_bus.stb   = 1'b0;
    m_bus.we    = 1'b0;
    m_bus.sel   = '0;
    m_bus.adr   = '0;
    m_bus.dat_m = '0;
    i_bus.ack   = 1'b0;
    i_bus.rty   = 1'b0;
    d_bus.ack   = 1'b0;
    d_bus.rty   = 1'b0;
    unique case (state)
      GRANT_I: begin
        m_bus.cyc   = i_req;
        m_bus.stb   = i_req;
        m_bus.we    = i_bus.we;
        m_bus.sel   = i_bus.sel;
        m_bus.adr   = i_bus.adr;
        m_bus.dat_m = i_bus.dat_m;
        i_bus.ack   = m_bus.ack;
        i_bus.rty   = m_bus.rty;
      end
      GRANT_D: begin
        m_bus.cyc   = d_req;
        m_bus.stb   = d_req;
        m_bus.we    = d_bus.we;
        m_bus.sel   = d_bus.sel;
        m_bus.adr   = d_bus.adr;
        m_bus.dat_m = d_bus.dat_m;
        d_bus.ack   = m_bus.ack;
        d_bus.rty   = m_bus.rty;
      end
      default: ;
    endcase
  end

  assign i_bus.dat_s = m_bus.dat_s;
  assign d_bus.dat_s = m_bus.dat_s;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and randomized bench for pmem_arbiter against a transaction-level ownership model.
module tb_pmem_arbiter;
  localparam int DATA_W = 128;
  localparam int ADR_W  = 12;
  localparam int SEL_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) i_bus ();
  pmem_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) d_bus ();
  pmem_arbiter_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) m_bus ();

  pmem_arbiter #(.DATA_W(DATA_W), .ADR_W(ADR_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus)
  );

  int tests  = 0;
  int failed = 0;

  // Model: who owns the downstream port (0 nobody, 1 I, 2 D), whether the
  // mandatory bubble is pending, and who last finished a transaction.
  int owner      = 0;
  bit bubble     = 0;
  int last_owner = 1;
  bit mdl_known  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit ir, input bit dr, input int last);
    if (ir && dr) return (last == 1) ? 2 : 1;
    if (dr) return 2;
    if (ir) return 1;
    return 0;
  endfunction

  task automatic mdl_update();
    bit ir, dr, fin;
    ir  = i_bus.cyc & i_bus.stb;
    dr  = d_bus.cyc & d_bus.stb;
    fin = m_bus.ack | m_bus.rty;
    if (rst) begin
      owner = 0; bubble = 0; last_owner = 1; mdl_known = 1;
    end else if (!mdl_known) begin
      // state undefined until the first reset
    end else if (bubble) begin
      bubble = 0;
    end else if (owner != 0) begin
      if (fin) begin
        last_owner = owner; owner = 0; bubble = 1;
      end else if (!((owner == 1) ? ir : dr)) begin
        owner = 0; bubble = 1;
      end
    end else begin
      owner = pick(ir, dr, last_owner);
    end
  endtask

  task automatic check_all();
    bit ir, dr, xr;
    logic              e_we;
    logic [SEL_W-1:0]  e_sel;
    logic [ADR_W-1:0]  e_adr;
    logic [DATA_W-1:0] e_dat;
    if (!mdl_known) return;
    ir = i_bus.cyc & i_bus.stb;
    dr = d_bus.cyc & d_bus.stb;
    xr = 0; e_we = 0; e_sel = '0; e_adr = '0; e_dat = '0;
    if (owner == 1) begin
      xr = ir; e_we = i_bus.we; e_sel = i_bus.sel; e_adr = i_bus.adr; e_dat = i_bus.dat_m;
    end else if (owner == 2) begin
      xr = dr; e_we = d_bus.we; e_sel = d_bus.sel; e_adr = d_bus.adr; e_dat = d_bus.dat_m;
    end
    chk("m_cyc", m_bus.cyc, xr);
    chk("m_stb", m_bus.stb, xr);
    chk("m_we", m_bus.we, e_we);
    chk("m_sel", m_bus.sel, e_sel);
    chk("m_adr", m_bus.adr, e_adr);
    chk("m_dat_m", m_bus.dat_m, e_dat);
    chk("i_ack", i_bus.ack, (owner == 1) ? m_bus.ack : 1'b0);
    chk("i_rty", i_bus.rty, (owner == 1) ? m_bus.rty : 1'b0);
    chk("d_ack", d_bus.ack, (owner == 2) ? m_bus.ack : 1'b0);
    chk("d_rty", d_bus.rty, (owner == 2) ? m_bus.rty : 1'b0);
    chk("i_dat_s", i_bus.dat_s, m_bus.dat_s);
    chk("d_dat_s", d_bus.dat_s, m_bus.dat_s);
  endtask

  task automatic settle();
    #4;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic set_req(input bit ir, input bit dr);
    i_bus.cyc = ir; i_bus.stb = ir;
    d_bus.cyc = dr; d_bus.stb = dr;
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 0);
    i_bus.we = 0; i_bus.sel = '0; i_bus.adr = 12'h111; i_bus.dat_m = '0;
    d_bus.we = 0; d_bus.sel = '0; d_bus.adr = 12'h222; d_bus.dat_m = '0;
    m_bus.ack = 0; m_bus.rty = 0; m_bus.dat_s = '0;
    tick();

    // Reset held with both requesting and a stray slave ACK
    set_req(1, 1);
    m_bus.ack = 1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rst_m_cyc", m_bus.cyc, 1'b0);
      chk("rst_i_ack", i_bus.ack, 1'b0);
      chk("rst_d_ack", d_bus.ack, 1'b0);
      tick();
    end
    rst = 1'b0; m_bus.ack = 0;
    settle();
    chk("rst_still_quiet", m_bus.cyc, 1'b0);
    tick();
    settle();
    chk("first_grant_cyc", m_bus.cyc, 1'b1);
    chk("first_grant_is_d", m_bus.adr, 12'h222);
    m_bus.ack = 1;
    settle();
    chk("first_grant_d_ack", d_bus.ack, 1'b1);
    chk("first_grant_i_ack", i_bus.ack, 1'b0);
    tick();
    m_bus.ack = 0; set_req(0, 0);
    settle();
    chk("release_cyc", m_bus.cyc, 1'b0);
    tick();

    // Single read, slave answers in the fifth cycle of m_cyc
    d_bus.adr = 12'h0A5; m_bus.dat_s = {4{32'h5A5A_0F0F}};
    set_req(0, 1);
    settle();
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rd_wait_cyc", m_bus.cyc, 1'b1);
      chk("rd_wait_adr", m_bus.adr, 12'h0A5);
      chk("rd_wait_d_ack", d_bus.ack, 1'b0);
      tick();
    end
    m_bus.ack = 1;
    settle();
    chk("rd_d_ack", d_bus.ack, 1'b1);
    chk("rd_d_dat_s", d_bus.dat_s, {4{32'h5A5A_0F0F}});
    chk("rd_i_ack", i_bus.ack, 1'b0);
    tick();
    m_bus.ack = 0; set_req(0, 0);
    settle();
    chk("rd_after_cyc", m_bus.cyc, 1'b0);
    chk("rd_after_d_ack", d_bus.ack, 1'b0);
    tick();

    // Contention from a fresh reset: D, I, D, I with a bubble between grants
    rst = 1'b1; settle(); tick(); rst = 1'b0;
    i_bus.adr = 12'h3C3; d_bus.adr = 12'h4B4;
    set_req(1, 1);
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("cont_idle_cyc", m_bus.cyc, 1'b0);
      tick();
      settle();
      chk("cont_grant_cyc", m_bus.cyc, 1'b1);
      chk("cont_grant_adr", m_bus.adr, (g % 2 == 0) ? 12'h4B4 : 12'h3C3);
      tick();
      m_bus.ack = 1;
      settle();
      chk("cont_d_ack", d_bus.ack, (g % 2 == 0) ? 1'b1 : 1'b0);
      chk("cont_i_ack", i_bus.ack, (g % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      m_bus.ack = 0;
      settle();
      chk("cont_release_cyc", m_bus.cyc, 1'b0);
      tick();
    end

    // Write passthrough from I
    set_req(1, 0);
    i_bus.we = 1; i_bus.sel = 16'hFFFF;
    i_bus.dat_m = 128'hDEADBEEF_CAFEF00D_01234567_8BADBEEF;
    settle();
    tick();
    settle();
    chk("wr_m_we", m_bus.we, 1'b1);
    chk("wr_m_sel", m_bus.sel, 16'hFFFF);
    chk("wr_m_dat_m", m_bus.dat_m, 128'hDEADBEEF_CAFEF00D_01234567_8BADBEEF);
    m_bus.ack = 1;
    settle();
    chk("wr_i_ack", i_bus.ack, 1'b1);
    chk("wr_d_ack", d_bus.ack, 1'b0);
    tick();
    m_bus.ack = 0; set_req(0, 0); i_bus.we = 0;
    settle(); tick();

    // Retry on D with I waiting: I goes next
    set_req(1, 1);
    settle();
    tick();
    settle();
    chk("rty_grant_d", m_bus.adr, 12'h4B4);
    m_bus.rty = 1;
    settle();
    chk("rty_d_rty", d_bus.rty, 1'b1);
    chk("rty_i_rty", i_bus.rty, 1'b0);
    chk("rty_i_ack", i_bus.ack, 1'b0);
    tick();
    m_bus.rty = 0;
    settle();
    chk("rty_release_cyc", m_bus.cyc, 1'b0);
    chk("rty_release_d_rty", d_bus.rty, 1'b0);
    tick();
    settle();
    tick();
    settle();
    chk("rty_next_cyc", m_bus.cyc, 1'b1);
    chk("rty_next_is_i", m_bus.adr, 12'h3C3);
    m_bus.ack = 1;
    settle();
    tick();
    m_bus.ack = 0; set_req(0, 0);
    settle(); tick();
    settle(); tick();

    // Abort leaves the round-robin pointer alone, then reset mid-grant
    set_req(0, 1);
    settle();
    tick();
    settle();
    chk("abort_grant_cyc", m_bus.cyc, 1'b1);
    d_bus.cyc = 0;
    settle();
    chk("abort_drop_cyc", m_bus.cyc, 1'b0);
    tick();
    settle();
    chk("abort_release_cyc", m_bus.cyc, 1'b0);
    tick();
    set_req(1, 1);
    settle();
    tick();
    settle();
    chk("abort_last_kept", m_bus.adr, 12'h4B4);
    rst = 1'b1;
    tick();
    m_bus.ack = 1;
    settle();
    chk("midrst_m_cyc", m_bus.cyc, 1'b0);
    chk("midrst_i_ack", i_bus.ack, 1'b0);
    chk("midrst_d_ack", d_bus.ack, 1'b0);
    rst = 1'b0; m_bus.ack = 0; set_req(0, 0);
    tick();

    // Randomized traffic, including slave responses outside a grant
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      i_bus.cyc   = ($urandom_range(0, 3) != 0);
      i_bus.stb   = ($urandom_range(0, 4) != 0);
      d_bus.cyc   = ($urandom_range(0, 3) != 0);
      d_bus.stb   = ($urandom_range(0, 4) != 0);
      i_bus.we    = $urandom_range(0, 1);
      d_bus.we    = $urandom_range(0, 1);
      i_bus.sel   = 16'($urandom);
      d_bus.sel   = 16'($urandom);
      i_bus.adr   = 12'($urandom);
      d_bus.adr   = 12'($urandom);
      i_bus.dat_m = {$urandom, $urandom, $urandom, $urandom};
      d_bus.dat_m = {$urandom, $urandom, $urandom, $urandom};
      m_bus.dat_s = {$urandom, $urandom, $urandom, $urandom};
      m_bus.ack   = ($urandom_range(0, 3) == 0);
      m_bus.rty   = ($urandom_range(0, 9) == 0);
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
